line_window_gen: RTL and testbench
==================================

# line_window_gen

Parametrised K-row sliding-column generator for the image-fix streaming pipeline, the successor to the fixed four-line buffer chain. It accepts one pixel per valid cycle in raster order and stores K-1 previous lines in circular line memories. Each accepted pixel produces a registered K-pixel vertical column: the current pixel plus the pixel at the same column in each of the K-1 lines above. It adds input stalls, start-of-frame resynchronisation, frame-position outputs and an optional top-border replication mode. It feeds the downstream kernel/filter stages.

## Interface
- WIDTH, 8, pixel bit width
- K, 5, window height in rows (2..8); K-1 line memories
- COL, 376, pixels per line
- ROW, 240, lines per frame
- clk  in  1  clock, all logic on rising edge
- en  in  1  asynchronous active-low reset; low clears all state
- din  in  WIDTH  input pixel
- din_valid  in  1  pixel accepted this cycle when high
- din_sof  in  1  qualified by din_valid; marks pixel (0,0) of a frame
- col_out  out  K*WIDTH  column; slice [i*WIDTH +: WIDTH] = pixel i lines above current (i=0 current)
- col_valid  out  1  col_out valid this cycle
- out_col  out  $clog2(COL)  column index of col_out
- out_row  out  $clog2(ROW)  row index of col_out (row of slice 0)
- frame_done  out  1  one-cycle pulse with the last column of a frame

## Operation
- Counters col_cnt and row_cnt advance only on accepted pixels (din_valid=1). col_cnt wraps COL-1→0 and increments row_cnt. At (ROW-1, COL-1) both wrap to 0.
- din_sof=1 with din_valid: this pixel is treated as (0,0) regardless of counter state, and the fill count is cleared. A mid-frame sof abandons the partial frame, and frame_done is not pulsed for it.
- Line memories: K-1 memories of COL words each, addressed by col_cnt. On an accepted pixel, memory j is read at col_cnt to form slice j+1. Memory 0 is written with din, and memory j is written with the old content of memory j-1, in the same cycle (read-before-write).
- fill: saturating count of completed lines since the last sof/wrap, 0..K-1. col_valid is high for an accepted pixel only when fill==K-1, i.e. rows K-1..ROW-1. The first K-1 rows produce no output.
- frame_done is high with the column for (ROW-1, COL-1).
- Memory contents are never cleared; fill gating alone prevents stale data from being emitted.
- din_valid=0: counters, memories and fill hold. col_valid=0 next cycle. col_out holds its last value.

## Timing
- Latency: exactly 1 cycle from accepted pixel to col_valid/col_out/out_col/out_row/frame_done.
- Full-rate throughput of 1 pixel/cycle. Arbitrary din_valid gaps are allowed with no loss.
- Reset values: col_out=0, col_valid=0, out_col=0, out_row=0, frame_done=0. Internal counters and fill are also 0.
- Reset asserted mid-frame: all outputs reach their reset values asynchronously. After release, the first accepted pixel is taken as (0,0) even without sof.
- Simultaneous wrap and sof: sof wins, and the pixel is (0,0) with fill=0.

## Configuration
- BORDER_REPLICATE_EN defined: col_valid is high for every accepted pixel from row 0. Any slice i > row index is replaced by the slice for row 0 of the current frame (top-edge replication). In row 0, all slices equal din.
- Not defined: no replication; output is suppressed for rows 0..K-2 as above.

## Test plan
- K=3, COL=8, ROW=6, din = row*16+col, continuous valid: first col_valid at (2,0) with col_out slices {0x20,0x10,0x00}. Last column is (5,7) {0x57,0x47,0x37} with frame_done=1. The bench checks 32 valid columns in total.
- Same stream with din_valid toggling 1,0,1,0: identical column sequence, each column 1 cycle after its accepted pixel, col_valid low on gap cycles.
- Back-to-back frames with sof on each (0,0): the second frame emits no columns for rows 0–1, and no frame-1 data leaks into frame-2 slices.
- sof asserted at (3,4) mid-frame: there is no frame_done for the abandoned frame, the next valid column is at (2,0) relative to the new sof, and the data comes only from new-frame pixels.
- en pulsed low at (4,2): outputs go to 0 immediately. After release, a stream without sof restarts at (0,0) and the first col_valid is at (2,0).
- With BORDER_REPLICATE_EN: pixel (0,3) gives col_out {0x03,0x03,0x03}, pixel (1,3) gives {0x13,0x03,0x03}, and the frame yields 48 valid columns.

Source files
------------

// File: rtl/line_window_gen_if.sv
// Pixel-in / column-out stream bundle for line_window_gen.
// master: pixel source and column sink; slave: the window generator.
interface line_window_gen_if #(
  parameter int WIDTH = 8,
  parameter int K     = 5,
  parameter int COL   = 376,
  parameter int ROW   = 240
);
  logic [WIDTH-1:0]       din;
  logic                   din_valid;
  logic                   din_sof;
  logic [K*WIDTH-1:0]     col_out;
  logic                   col_valid;
  logic [$clog2(COL)-1:0] out_col;
  logic [$clog2(ROW)-1:0] out_row;
  logic                   frame_done;

  modport master (
    output din, din_valid, din_sof,
    input  col_out, col_valid, out_col, out_row, frame_done
  );

  modport slave (
    input  din, din_valid, din_sof,
    output col_out, col_valid, out_col, out_row, frame_done
  );
endinterface

// File: rtl/line_window_gen.sv
// K-row sliding column generator over K-1 circular line memories.
// Ports: clk, en (async active-low reset), bus (slave: din/valid/sof in,
// col_out/col_valid/out_col/out_row/frame_done out).
// Option: define BORDER_REPLICATE_EN for top-edge replication from row 0.
module line_window_gen #(
  parameter int WIDTH = 8,
  parameter int K     = 5,
  parameter int COL   = 376,
  parameter int ROW   = 240
) (
  input logic             clk,
  input logic             en,
  line_window_gen_if.slave bus
);
  localparam int CW = $clog2(COL);
  localparam int RW = $clog2(ROW);
  localparam int FW = $clog2(K);
  localparam logic [CW-1:0] CLAST = CW'(COL - 1);
  localparam logic [RW-1:0] RLAST = RW'(ROW - 1);
  localparam logic [FW-1:0] FMAX  = FW'(K - 1);

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [FW-1:0] fill;

  logic          acc;
  logic          restart;
  logic [CW-1:0] cc;
  logic [RW-1:0] rr;
  logic [FW-1:0] ff;
  logic          col_last;
  logic          row_last;
  logic          full;

  logic [WIDTH-1:0] mem [K-1][COL];
  logic [WIDTH-1:0] tap [K];
  logic [K*WIDTH-1:0] col_nxt;
  logic               vld_nxt;
  logic               done_nxt;

  // sof overrides the counters for this very pixel
  assign acc      = bus.din_valid;
  assign restart  = acc & bus.din_sof;
  assign cc       = restart ? '0 : col_cnt;
  assign rr       = restart ? '0 : row_cnt;
  assign ff       = restart ? '0 : fill;
  assign col_last = (cc == CLAST);
  assign row_last = (rr == RLAST);
  assign full     = (ff == FMAX);

  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      col_cnt <= '0;
      row_cnt <= '0;
      fill    <= '0;
    end else if (acc) begin
      if (col_last) begin
        col_cnt <= '0;
        if (row_last) begin
          row_cnt <= '0;
          fill    <= '0;
        end else begin
          row_cnt <= rr + RW'(1);
          fill    <= full ? ff : ff + FW'(1);
        end
      end else begin
        col_cnt <= cc + CW'(1);
        row_cnt <= rr;
        fill    <= ff;
      end
    end
  end

  // Shift the column down the memory chain; reads see pre-write data.
  always_ff @(posedge clk) begin
    if (acc) begin
      mem[0][cc] <= bus.din;
      for (int j = 1; j < K - 1; j++) begin
        mem[j][cc] <= mem[j-1][cc];
      end
    end
  end

  always_comb begin
    tap[0] = bus.din;
    for (int j = 0; j < K - 1; j++) begin
      tap[j+1] = mem[j][cc];
    end
    col_nxt = '0;
    for (int i = 0; i < K; i++) begin
`ifdef BORDER_REPLICATE_EN
      // rows above the frame top reuse the row-0 pixel
      col_nxt[i*WIDTH +: WIDTH] = (FW'(i) > ff) ? tap[ff] : tap[i];
`else
      col_nxt[i*WIDTH +: WIDTH] = tap[i];
`endif
    end
  end

`ifdef BORDER_REPLICATE_EN
  assign vld_nxt = acc;
`else
  assign vld_nxt = acc & full;
`endif
  assign done_nxt = vld_nxt & col_last & row_last;

  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      bus.col_out    <= '0;
      bus.col_valid  <= 1'b0;
      bus.out_col    <= '0;
      bus.out_row    <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.col_valid  <= vld_nxt;
      bus.frame_done <= done_nxt;
      if (acc) begin
        bus.col_out <= col_nxt;
        bus.out_col <= cc;
        bus.out_row <= rr;
      end
    end
  end
endmodule

// File: tb/tb_line_window_gen.sv
// Directed bench for line_window_gen (K=3, COL=8, ROW=6).
// Pixel value = offset + row*16 + col; expectations computed here.
module tb_line_window_gen;
  localparam int W = 8;
  localparam int K = 3;
  localparam int COL = 8;
  localparam int ROW = 6;
`ifdef BORDER_REPLICATE_EN
  localparam int NV = 48;
`else
  localparam int NV = 32;
`endif

  logic clk = 1'b0;
  logic en  = 1'b0;
  int   nchk = 0;
  int   nerr = 0;
  int   nvalid;
  logic [K*W-1:0] last_exp;
  bit   last_v;

  always #5 clk = ~clk;

  line_window_gen_if #(.WIDTH(W), .K(K), .COL(COL), .ROW(ROW)) bus ();

  line_window_gen #(.WIDTH(W), .K(K), .COL(COL), .ROW(ROW)) dut (
    .clk (clk),
    .en  (en),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic px(input int off, input int r, input int c, input bit sof);
    logic [K*W-1:0] e;
    bit v;
    int rs;
    for (int i = 0; i < K; i++) begin
      rs = (r - i < 0) ? 0 : r - i;
      e[i*W +: W] = W'(off + 16 * rs + c);
    end
`ifdef BORDER_REPLICATE_EN
    v = 1'b1;
`else
    v = (r >= K - 1);
`endif
    bus.din       = W'(off + 16 * r + c);
    bus.din_valid = 1'b1;
    bus.din_sof   = sof;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.din_sof   = 1'b0;
    check("col_valid", 64'(bus.col_valid), 64'(v));
    check("frame_done", 64'(bus.frame_done),
          64'(v && r == ROW - 1 && c == COL - 1));
    if (v) begin
      nvalid++;
      check("col_out", 64'(bus.col_out), 64'(e));
      check("out_row", 64'(bus.out_row), 64'(r));
      check("out_col", 64'(bus.out_col), 64'(c));
    end
    last_exp = e;
    last_v   = v;
  endtask

  task automatic gap_cyc();
    bus.din_valid = 1'b0;
    @(posedge clk);
    #1;
    check("gap_valid", 64'(bus.col_valid), 64'd0);
    check("gap_done", 64'(bus.frame_done), 64'd0);
    if (last_v) check("gap_hold", 64'(bus.col_out), 64'(last_exp));
  endtask

  task automatic frame(input int off, input bit sof, input bit gap,
                       input string tag);
    nvalid = 0;
    for (int r = 0; r < ROW; r++) begin
      for (int c = 0; c < COL; c++) begin
        px(off, r, c, sof && r == 0 && c == 0);
        if (gap) gap_cyc();
      end
    end
    check(tag, 64'(nvalid), 64'(NV));
  endtask

  task automatic partial(input int off, input int n);
    for (int p = 0; p < n; p++) begin
      px(off, p / COL, p % COL, p == 0);
    end
  endtask

  initial begin
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.din_sof   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_col_out", 64'(bus.col_out), 64'd0);
    check("rst_valid", 64'(bus.col_valid), 64'd0);
    check("rst_out_col", 64'(bus.out_col), 64'd0);
    check("rst_out_row", 64'(bus.out_row), 64'd0);
    check("rst_done", 64'(bus.frame_done), 64'd0);
    en = 1'b1;
    @(posedge clk);
    #1;

    frame(8'h00, 1'b1, 1'b0, "n_cont");
    frame(8'h00, 1'b0, 1'b1, "n_gap");
    frame(8'h80, 1'b1, 1'b0, "n_b2b");

    // abandon at (3,4): new sof there restarts the frame
    partial(8'h10, 3 * COL + 4);
    frame(8'h20, 1'b1, 1'b0, "n_midsof");

    // reset mid-frame right after pixel (4,2)
    partial(8'h00, 4 * COL + 3);
    en = 1'b0;
    #1;
    check("arst_col_out", 64'(bus.col_out), 64'd0);
    check("arst_valid", 64'(bus.col_valid), 64'd0);
    check("arst_out_col", 64'(bus.out_col), 64'd0);
    check("arst_out_row", 64'(bus.out_row), 64'd0);
    check("arst_done", 64'(bus.frame_done), 64'd0);
    #2;
    en = 1'b1;
    frame(8'h40, 1'b0, 1'b0, "n_after_rst");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
